core_hazard_ctrl: RTL

//  Pipeline sequencer for the 5-stage core (IF/ID/EX/MEM/WB). Consumes decoded ID-stage

---
 rtl/core_hazard_ctrl.sv | 130 +++++++++++++
 1 files changed

// File: rtl/core_hazard_ctrl.sv
// rtl/core_hazard_ctrl.sv - stall/bubble/flush sequencing and registered EX forwarding selects
module core_hazard_ctrl #(
    parameter int IMEM_LAT = 1,
    parameter int CNT_W    = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             id_valid,
    input  logic             id_want_rs1,
    input  logic             id_want_rs2,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic             ex_valid,
    input  logic             ex_reg_wen,
    input  logic             ex_mem_ren,
    input  logic [4:0]       ex_rd,
    input  logic             mem_valid,
    input  logic             mem_reg_wen,
    input  logic [4:0]       mem_rd,
    input  logic             ex_redirect,
    input  logic             dmem_req,
    input  logic             dmem_ready,
    output logic             stall_if,
    output logic             stall_id,
    output logic             stall_exmem,
    output logic             bubble_ex,
    output logic             flush_id,
    output logic [1:0]       fwd_a,
    output logic [1:0]       fwd_b,
    output logic [CNT_W-1:0] stall_cnt
);

    typedef enum logic {
        RUN   = 1'b0,
        DRAIN = 1'b1
    } state_t;

    localparam logic [2:0] LAT = 3'(IMEM_LAT);

    state_t     state;
    logic [2:0] drain_cnt;

    logic ex_hit_1, ex_hit_2, mem_hit_1, mem_hit_2;
    logic load_use, mwait;
    logic [1:0] fwd_a_nxt, fwd_b_nxt;

    assign ex_hit_1  = ex_valid & ex_reg_wen & (ex_rd != 5'd0) & (ex_rd == id_rs1) & id_want_rs1;
    assign ex_hit_2  = ex_valid & ex_reg_wen & (ex_rd != 5'd0) & (ex_rd == id_rs2) & id_want_rs2;
    assign mem_hit_1 = mem_valid & mem_reg_wen & (mem_rd != 5'd0) & (mem_rd == id_rs1) & id_want_rs1;
    assign mem_hit_2 = mem_valid & mem_reg_wen & (mem_rd != 5'd0) & (mem_rd == id_rs2) & id_want_rs2;
    assign load_use  = id_valid & (ex_hit_1 | ex_hit_2) & ex_mem_ren;
    assign mwait     = dmem_req & ~dmem_ready;

    // The youngest producer (EX) wins; a WB-stage producer is covered by the write-first regfile.
    assign fwd_a_nxt = ex_hit_1 ? 2'd1 : (mem_hit_1 ? 2'd2 : 2'd0);
    assign fwd_b_nxt = ex_hit_2 ? 2'd1 : (mem_hit_2 ? 2'd2 : 2'd0);

    always_comb begin
        stall_if    = 1'b0;
        stall_id    = 1'b0;
        stall_exmem = 1'b0;
        bubble_ex   = 1'b0;
        flush_id    = 1'b0;
        if (rst_n) begin
            if (mwait) begin
                // EX is frozen, so a pending redirect simply re-presents once memory completes.
                stall_if    = 1'b1;
                stall_id    = 1'b1;
                stall_exmem = 1'b1;
            end else if (ex_redirect) begin
                flush_id  = 1'b1;
                bubble_ex = 1'b1;
            end else if (state == DRAIN) begin
                flush_id = 1'b1;
            end else if (load_use) begin
                stall_if  = 1'b1;
                stall_id  = 1'b1;
                bubble_ex = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= RUN;
            drain_cnt <= 3'd0;
        end else if (!mwait) begin
            if (ex_redirect) begin
                if (IMEM_LAT > 0) begin
                    state     <= DRAIN;
                    drain_cnt <= LAT;
                end else begin
                    state     <= RUN;
                    drain_cnt <= 3'd0;
                end
            end else if (state == DRAIN) begin
                if (drain_cnt <= 3'd1) begin
                    state     <= RUN;
                    drain_cnt <= 3'd0;
                end else begin
                    drain_cnt <= drain_cnt - 3'd1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            fwd_a <= 2'd0;
            fwd_b <= 2'd0;
        end else if (!stall_exmem) begin
            if (bubble_ex) begin
                fwd_a <= 2'd0;
                fwd_b <= 2'd0;
            end else begin
                fwd_a <= fwd_a_nxt;
                fwd_b <= fwd_b_nxt;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stall_cnt <= '0;
        end else if (stall_if && (stall_cnt != {CNT_W{1'b1}})) begin
            stall_cnt <= stall_cnt + 1'b1;
        end
    end

endmodule
